// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants, channel-index type and index-width helper
// for the multi-channel tick generator.
//   TICK_NCH_MAX   - largest supported channel count
//   TICK_WIDTH_MAX - largest supported counter/divisor width
//   tick_chan_t    - channel index wide enough for TICK_NCH_MAX channels
//   tick_idx_width - bits needed to address n channels (never below 1)
package tick_gen_pkg;

  localparam int unsigned TICK_NCH_MAX   = 16;
  localparam int unsigned TICK_WIDTH_MAX = 32;

  typedef logic [$clog2(TICK_NCH_MAX)-1:0] tick_chan_t;

  function automatic int unsigned tick_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one tick-generator channel (counter, divisor, registered tick).
// Optional feature macro: TICK_SQUARE_EN adds a 50%-duty square output.
// Ports:
//   clock_in  - system clock, posedge
//   resetn    - asynchronous active-low reset
//   en        - run enable; counter and square hold while low
//   restart   - synchronous clear of counter/tick(/square); divisor kept
//   wr        - load new_div into the divisor and clear the counter
//   new_div   - divisor value for wr
//   tick      - registered one-cycle pulse, one per div+1 enabled cycles
//   square    - (TICK_SQUARE_EN) toggles whenever tick goes high
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int unsigned      WIDTH       = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [WIDTH-1:0] new_div,
  output logic             tick
`ifdef TICK_SQUARE_EN
  ,
  output logic             square
`endif
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div;

  // Priority: restart, then write, then normal counting. A write never
  // emits a tick in its accept cycle, even when cnt == div.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      div  <= DEFAULT_DIV;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (wr) begin
      div  <= new_div;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en && (cnt == div)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else if (en) begin
      cnt  <= cnt + WIDTH'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_SQUARE_EN
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      square <= 1'b0;
    end else if (restart || wr) begin
      square <= 1'b0;
    end else if (en && (cnt == div)) begin
      square <= ~square;
    end
  end
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH independent clock-enable tick generators with a runtime
// divisor write port (valid/ready). Period of channel i is div[i]+1 cycles.
// Optional feature macro: TICK_SQUARE_EN adds the square output port.
// Ports:
//   clock_in  - system clock, posedge
//   resetn    - asynchronous active-low reset
//   enable    - per-channel run enable
//   restart   - synchronous phase-align: clears every counter
//   cfg_valid - divisor write request
//   cfg_ready - write accepted this cycle (resetn high and restart low)
//   cfg_chan  - target channel; indices >= NCH are accepted and dropped
//   cfg_div   - new divisor
//   tick      - registered one-cycle pulse per channel
//   square    - (TICK_SQUARE_EN) registered 50%-duty toggle per channel
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned      NCH         = 4,
  parameter int unsigned      WIDTH       = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic                              clock_in,
  input  logic                              resetn,
  input  logic [NCH-1:0]                    enable,
  input  logic                              restart,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [tick_idx_width(NCH)-1:0]    cfg_chan,
  input  logic [WIDTH-1:0]                  cfg_div,
  output logic [NCH-1:0]                    tick
`ifdef TICK_SQUARE_EN
  ,
  output logic [NCH-1:0]                    square
`endif
);

  logic accept;

  assign cfg_ready = resetn & ~restart;
  assign accept    = cfg_valid & cfg_ready;

  // Out-of-range channel indices match no generated channel, so such a
  // write completes its handshake without touching any state.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = accept && (tick_chan_t'(cfg_chan) == tick_chan_t'(i));

    tick_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clock_in(clock_in),
      .resetn  (resetn),
      .en      (enable[i]),
      .restart (restart),
      .wr      (wr),
      .new_div (cfg_div),
      .tick    (tick[i])
`ifdef TICK_SQUARE_EN
      ,
      .square  (square[i])
`endif
    );
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised multi-channel tick generator; the successor to the single fixed-ratio clock-divider pulse generator. It produces NCH independent one-cycle enable pulses ("ticks") from one system clock. Each channel has a divisor that can be reprogrammed at runtime through a simple valid/ready write port. It sits beside the CPU and peripherals as the shared source of slow strobes (LED blink, UART baud, debug single-stepping), and replaces divided clocks with clock enables.

## Interface
- NCH, 4: number of channels, 1..16
- WIDTH, 24: counter/divisor width, 2..32
- DEFAULT_DIV, 2**WIDTH-1: divisor loaded into every channel at reset
- clock_in  in  1  system clock; all logic on posedge
- resetn  in  1  asynchronous, active-low reset; deassertion synchronous to clock_in externally
- enable  in  NCH  per-channel run enable
- restart  in  1  synchronous global phase-align: clears all counters
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write accepted this cycle
- cfg_chan  in  $clog2(NCH) (min 1)  target channel
- cfg_div  in  WIDTH  new divisor
- tick  out  NCH  registered one-cycle pulse per channel
- square  out  NCH  registered toggle output; present only with TICK_SQUARE_EN

## Operation
- Per channel: counter cnt, divisor div. Period is div+1 cycles; one tick per period.
- Enabled channel with cnt == div: next cycle cnt=0 and tick=1. Otherwise cnt=cnt+1 and tick=0.
- div = 0: tick held high continuously while enabled.
- Channel disabled: cnt holds, tick=0. Re-enabling resumes from the held count, with no extra tick.
- Write: handshake completes when cfg_valid && cfg_ready. cfg_ready is 1 whenever resetn is high and restart is low. div[cfg_chan] is updated and that channel's cnt is cleared. No tick is issued in the accept cycle, even if cnt == div.
- cfg_chan >= NCH: write is accepted and discarded, with no state change.
- restart: all cnt cleared and all tick 0 next cycle; div is unchanged. restart overrides a write, because cfg_ready is 0 that cycle.
- Counter arithmetic is unsigned, modulo 2**WIDTH. cnt never exceeds div, except after a write that lowered div, which is impossible because a write clears cnt.

## Timing
- Reset values (async): cnt=0, div=DEFAULT_DIV, tick=0, square=0, cfg_ready=0.
- First tick after reset release with enable high: on the cycle after cnt reaches div, i.e. div+1 rising edges after the first active edge.
- Write latency: the new div governs from the next cycle. The first tick after a write appears div_new+1 cycles after the accept edge.
- Outputs are fully registered; there is no combinational path from inputs to tick or square. cfg_ready is combinational from resetn and restart only.
- Reset asserted mid-period: all state returns to reset values immediately; no partial tick.

## Configuration
- TICK_SQUARE_EN defined:
  - each channel keeps a square register that toggles in the same cycle its tick goes high, giving 50% duty and period 2*(div+1);
  - restart and cfg writes clear square to 0;
  - while the channel is disabled, square holds its value.
- TICK_SQUARE_EN undefined: the square port and its register are absent.

## Structure
- Package tick_gen_pkg:
  - constants TICK_NCH_MAX=16 and TICK_WIDTH_MAX=32;
  - a typedef for the channel-index type;
  - a function computing the index width (min 1).
- Sub-module tick_channel: one counter/divisor/tick (and optional square). Instantiated NCH times by a generate loop in tick_gen, which owns write decoding and cfg_ready.

## Test plan
- Reset, NCH=2, WIDTH=4, DEFAULT_DIV=3, enable=2'b11 → ticks on both channels every 4 cycles, in phase; first tick 4 cycles after release.
- Write chan 1 div=0 → tick[1] high every cycle from the cycle after accept; tick[0] unaffected.
- Write chan 0 div=5 on the cycle cnt0==3 → no tick that cycle; next tick[0] 6 cycles later.
- enable[0] low for 7 cycles mid-period, then high → tick[0] delayed by exactly 7 cycles; no spurious pulse.
- restart with cfg_valid high → cfg_ready=0, write ignored, all counters zero, ticks realigned.
- TICK_SQUARE_EN, div=3 → square[0] period 8 cycles, high 4/low 4; async reset asserted mid-high → square=0 immediately.
